// File: rtl/spi_word_assembler.sv
// spi_word_assembler
// Packs MSB-first SPI bytes into WORD_BYTES-wide scene words for the raytracing
// controller. It keeps one pending word when the controller is not ready,
// drops and flags a word that would overwrite the pending one, and discards
// partial words on a chip-select rise or an inter-byte timeout. Every accepted
// word is answered with ACK_BYTE. Every dropped or discarded word is answered
// with NAK_BYTE.
module spi_word_assembler #(
  parameter int                        WORD_BYTES     = 8,
  parameter int                        TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]                ACK_BYTE       = 8'hA5,
  parameter logic [7:0]                NAK_BYTE       = 8'h5A,
  parameter logic [WORD_BYTES*8-1:0]   RESET_WORD     = '0
) (
  input  logic                         CLK100MHZ,
  input  logic                         ck_rst_,
  input  logic                         byte_dv,
  input  logic [7:0]                   byte_in,
  input  logic                         spi_cs_n,
  input  logic                         recv_interrupt,
  input  logic                         clr_flags,
  output logic                         recv_dv,
  output logic [WORD_BYTES*8-1:0]      recv_64bit,
  output logic                         tran_dv,
  output logic [7:0]                   tran_byte,
  output logic                         pending_valid,
  output logic                         overflow,
  output logic                         frame_err
);

  localparam int WORD_W = WORD_BYTES * 8;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  // Control state
  logic [CNT_W-1:0]  byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              armed;
  logic              int_q;
  logic              cs_q;

  // Data state (no reset: contents are qualified by byte_cnt / pending_valid)
  logic [WORD_W-9:0] shift_q;
  logic [WORD_W-1:0] pend_word;

  // Per-cycle decisions
  logic              take;
  logic              complete;
  logic              cs_rise;
  logic              int_edge;
  logic              timeout;
  logic              abort;
  logic              deliver_pend;
  logic              deliver_new;
  logic              deliver;
  logic              pend_load;
  logic              drop;
  logic [WORD_W-1:0] new_word;

  // Decode this cycle's events: byte capture, word completion, abort and delivery routing.
  always_comb begin
    take         = byte_dv & ~spi_cs_n;
    complete     = take && (byte_cnt == CNT_LAST);
    cs_rise      = spi_cs_n & ~cs_q;
    int_edge     = recv_interrupt & ~int_q;
    new_word     = {shift_q, byte_in};

    // Timeout fires on the TIMEOUT_CYCLES-th consecutive idle clock of a partial word.
    timeout      = (byte_cnt != '0) && !take && (idle_cnt == IDLE_LAST);
    // A completion already returns byte_cnt to zero, so it takes priority over abort.
    abort        = (byte_cnt != '0) && !complete && (cs_rise || timeout);

    // The pending word always goes first so words reach the controller in order.
    deliver_pend = armed && pending_valid;
    deliver_new  = complete && armed && !pending_valid;
    deliver      = deliver_pend || deliver_new;

    // The pending buffer refills either behind a pending delivery or when the controller is not ready.
    pend_load    = complete && (deliver_pend || (!armed && !pending_valid));
    drop         = complete && pending_valid && !armed;
  end

  // Track input history for edge detection on chip select and the consume level.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      int_q <= 1'b0;
      cs_q  <= 1'b1;
    end else begin
      int_q <= recv_interrupt;
      cs_q  <= spi_cs_n;
    end
  end

  // Byte position inside the word currently being assembled.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      byte_cnt <= '0;
    end else if (take) begin
      byte_cnt <= complete ? '0 : byte_cnt + 1'b1;
    end else if (abort) begin
      byte_cnt <= '0;
    end
  end

  // Idle clocks since the last byte taken, counted only while a word is partial.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      idle_cnt <= '0;
    end else if (take || abort || (byte_cnt == '0)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Shift incoming bytes in MSB-first; the final byte is merged combinationally.
  always_ff @(posedge CLK100MHZ) begin
    if (take) begin
      shift_q <= new_word[WORD_W-9:0];
    end
  end

  // Hold the one word waiting for the controller.
  always_ff @(posedge CLK100MHZ) begin
    if (pend_load) begin
      pend_word <= new_word;
    end
  end

  // Controller readiness: a consume edge arms, a delivery disarms, the edge wins a tie.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      armed <= 1'b1;
    end else if (int_edge) begin
      armed <= 1'b1;
    end else if (deliver) begin
      armed <= 1'b0;
    end
  end

  // Pending buffer occupancy.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      pending_valid <= 1'b0;
    end else if (pend_load) begin
      pending_valid <= 1'b1;
    end else if (deliver_pend) begin
      pending_valid <= 1'b0;
    end
  end

  // Word delivery strobe and the held output word.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      recv_dv    <= 1'b0;
      recv_64bit <= RESET_WORD;
    end else begin
      recv_dv <= deliver;
      if (deliver_pend) begin
        recv_64bit <= pend_word;
      end else if (deliver_new) begin
        recv_64bit <= new_word;
      end
    end
  end

  // Status byte back to the MCU: ACK for accepted words, NAK for drops and aborts.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      tran_dv   <= 1'b0;
      tran_byte <= 8'h00;
    end else if (complete) begin
      tran_dv   <= 1'b1;
      tran_byte <= drop ? NAK_BYTE : ACK_BYTE;
    end else if (abort) begin
      tran_dv   <= 1'b1;
      tran_byte <= NAK_BYTE;
    end else begin
      tran_dv   <= 1'b0;
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (abort) begin
        frame_err <= 1'b1;
      end else if (clr_flags) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule
